// File: rtl/rom_rr_arbiter_if.sv
// Bus bundle between the ROM arbiter, its two requesters and the shared ROM.
// The slave modport is the arbiter's view; master is the requesters/ROM side.
interface rom_rr_arbiter_if #(
  parameter int AW = 3,
  parameter int DW = 4
);
  logic          req_a;
  logic [AW-1:0] addr_a;
  logic          gnt_a;
  logic          rvalid_a;
  logic [DW-1:0] rdata_a;
  logic          req_b;
  logic [AW-1:0] addr_b;
  logic          gnt_b;
  logic          rvalid_b;
  logic [DW-1:0] rdata_b;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic          busy;

  modport slave (
    input  req_a, addr_a, req_b, addr_b, rom_data,
    output gnt_a, rvalid_a, rdata_a, gnt_b, rvalid_b, rdata_b, rom_addr, busy
  );

  modport master (
    output req_a, addr_a, req_b, addr_b, rom_data,
    input  gnt_a, rvalid_a, rdata_a, gnt_b, rvalid_b, rdata_b, rom_addr, busy
  );
endinterface

// File: rtl/rom_rr_arbiter.sv
// Round-robin arbiter sharing one synchronous lookup ROM between requesters A and B.
// One access in flight at a time; read data is returned with a one-cycle valid pulse.
module rom_rr_arbiter #(
  parameter int AW      = 3,
  parameter int DW      = 4,
  parameter int ROM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  rom_rr_arbiter_if.slave   bus
);
  localparam int            CW    = $clog2(ROM_LAT + 1);
  localparam logic [CW-1:0] LAT_C = CW'(ROM_LAT);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t        state_r;
  logic [CW-1:0] cnt_r;
  logic          last_r;      // 1'b1 = B won last, and also the current owner while in WAIT
  logic          gnt_a_r;
  logic          gnt_b_r;
  logic          rvalid_a_r;
  logic          rvalid_b_r;
  logic [DW-1:0] rdata_a_r;
  logic [DW-1:0] rdata_b_r;
  logic [AW-1:0] rom_addr_r;
  logic          busy_r;

  logic          req_any_s;
  logic          win_b_s;
  logic [AW-1:0] addr_win_s;

  // Winner selection: a lone requester wins, a tie goes to whoever did not win last.
  always_comb begin
    win_b_s   = 1'b0;
    req_any_s = bus.req_a | bus.req_b;
    if (bus.req_a && bus.req_b) begin
      win_b_s = ~last_r;
    end else if (bus.req_b) begin
      win_b_s = 1'b1;
    end else begin
      win_b_s = 1'b0;
    end
    addr_win_s = win_b_s ? bus.addr_b : bus.addr_a;
  end

  // Arbitration FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      cnt_r      <= {CW{1'b0}};
      last_r     <= 1'b1;
      gnt_a_r    <= 1'b0;
      gnt_b_r    <= 1'b0;
      rvalid_a_r <= 1'b0;
      rvalid_b_r <= 1'b0;
      rdata_a_r  <= {DW{1'b0}};
      rdata_b_r  <= {DW{1'b0}};
      rom_addr_r <= {AW{1'b0}};
      busy_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          rvalid_a_r <= 1'b0;
          rvalid_b_r <= 1'b0;
          if (req_any_s) begin
            rom_addr_r <= addr_win_s;
            gnt_a_r    <= ~win_b_s;
            gnt_b_r    <= win_b_s;
            last_r     <= win_b_s;
            cnt_r      <= {CW{1'b0}};
            busy_r     <= 1'b1;
            state_r    <= WAIT;
          end else begin
            gnt_a_r <= 1'b0;
            gnt_b_r <= 1'b0;
          end
        end
        WAIT: begin
          gnt_a_r <= 1'b0;
          gnt_b_r <= 1'b0;
          // cnt counts edges since the ROM sampled the address; data is valid at LAT_C.
          if (cnt_r == LAT_C) begin
            if (last_r) begin
              rdata_b_r  <= bus.rom_data;
              rvalid_b_r <= 1'b1;
            end else begin
              rdata_a_r  <= bus.rom_data;
              rvalid_a_r <= 1'b1;
            end
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end else begin
            cnt_r      <= cnt_r + CW'(1'b1);
            rvalid_a_r <= 1'b0;
            rvalid_b_r <= 1'b0;
          end
        end
        default: begin
          state_r    <= IDLE;
          gnt_a_r    <= 1'b0;
          gnt_b_r    <= 1'b0;
          rvalid_a_r <= 1'b0;
          rvalid_b_r <= 1'b0;
          busy_r     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt_a    = gnt_a_r;
  assign bus.gnt_b    = gnt_b_r;
  assign bus.rvalid_a = rvalid_a_r;
  assign bus.rvalid_b = rvalid_b_r;
  assign bus.rdata_a  = rdata_a_r;
  assign bus.rdata_b  = rdata_b_r;
  assign bus.rom_addr = rom_addr_r;
  assign bus.busy     = busy_r;
endmodule

// File: tb/tb_rom_rr_arbiter.sv
// Directed bench for rom_rr_arbiter: two instances (ROM_LAT=1 and ROM_LAT=3)
// share the same stimulus; one is observed at a time through a selector.
module tb_rom_rr_arbiter;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_a, req_b;
  logic [2:0] addr_a, addr_b;
  int         lat_sel = 0;
  int         lat = 1;
  int         n_cmp = 0;
  int         n_err = 0;
  logic [3:0] exp_rd_a, exp_rd_b;

  always #5 clk = ~clk;

  rom_rr_arbiter_if #(.AW(3), .DW(4)) if1 ();
  rom_rr_arbiter_if #(.AW(3), .DW(4)) if3 ();

  rom_rr_arbiter #(.AW(3), .DW(4), .ROM_LAT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  rom_rr_arbiter #(.AW(3), .DW(4), .ROM_LAT(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));

  assign if1.req_a = req_a;  assign if1.addr_a = addr_a;
  assign if1.req_b = req_b;  assign if1.addr_b = addr_b;
  assign if3.req_a = req_a;  assign if3.addr_a = addr_a;
  assign if3.req_b = req_b;  assign if3.addr_b = addr_b;

  function automatic logic [3:0] rom_f(input logic [2:0] a);
    case (a)
      3'd0: rom_f = 4'h9;
      3'd1: rom_f = 4'h2;
      3'd2: rom_f = 4'hc;
      3'd3: rom_f = 4'h5;
      3'd4: rom_f = 4'he;
      3'd5: rom_f = 4'h7;
      3'd6: rom_f = 4'h0;
      3'd7: rom_f = 4'hb;
      default: rom_f = 4'h0;
    endcase
  endfunction

  // ROM models: one register stage per latency edge.
  logic [3:0] r1_q, r3_q0, r3_q1, r3_q2;
  always @(posedge clk) begin
    r1_q  <= rom_f(if1.rom_addr);
    r3_q0 <= rom_f(if3.rom_addr);
    r3_q1 <= r3_q0;
    r3_q2 <= r3_q1;
  end
  assign if1.rom_data = r1_q;
  assign if3.rom_data = r3_q2;

  logic       o_gnt_a, o_gnt_b, o_rv_a, o_rv_b, o_busy;
  logic [3:0] o_rd_a, o_rd_b;
  logic [2:0] o_rom_addr;
  assign o_gnt_a    = lat_sel != 0 ? if3.gnt_a    : if1.gnt_a;
  assign o_gnt_b    = lat_sel != 0 ? if3.gnt_b    : if1.gnt_b;
  assign o_rv_a     = lat_sel != 0 ? if3.rvalid_a : if1.rvalid_a;
  assign o_rv_b     = lat_sel != 0 ? if3.rvalid_b : if1.rvalid_b;
  assign o_rd_a     = lat_sel != 0 ? if3.rdata_a  : if1.rdata_a;
  assign o_rd_b     = lat_sel != 0 ? if3.rdata_b  : if1.rdata_b;
  assign o_rom_addr = lat_sel != 0 ? if3.rom_addr : if1.rom_addr;
  assign o_busy     = lat_sel != 0 ? if3.busy     : if1.busy;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL L%0d %s: got %0h expected %0h", lat, tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full access: grant edge, lat waiting edges, capture edge.
  task automatic do_slot(input string tag, input logic exp_b, input logic [2:0] exp_addr,
                         input logic [3:0] exp_data);
    tick();
    check_eq({tag, " gnt_a"}, 32'(o_gnt_a), 32'(!exp_b));
    check_eq({tag, " gnt_b"}, 32'(o_gnt_b), 32'(exp_b));
    check_eq({tag, " rom_addr"}, 32'(o_rom_addr), 32'(exp_addr));
    check_eq({tag, " busy"}, 32'(o_busy), 32'd1);
    for (int j = 0; j < lat; j++) begin
      tick();
      check_eq({tag, " wait busy"}, 32'(o_busy), 32'd1);
      check_eq({tag, " wait rv"}, 32'({o_rv_a, o_rv_b}), 32'd0);
      check_eq({tag, " wait gnt"}, 32'({o_gnt_a, o_gnt_b}), 32'd0);
    end
    tick();
    if (exp_b) exp_rd_b = exp_data;
    else       exp_rd_a = exp_data;
    check_eq({tag, " rvalid"}, 32'({o_rv_a, o_rv_b}), exp_b ? 32'd1 : 32'd2);
    check_eq({tag, " rdata_a"}, 32'(o_rd_a), 32'(exp_rd_a));
    check_eq({tag, " rdata_b"}, 32'(o_rd_b), 32'(exp_rd_b));
    check_eq({tag, " busy end"}, 32'(o_busy), 32'd0);
  endtask

  task automatic run_suite();
    // Reset with a request pending: nothing may be granted.
    rst_n = 1'b0; req_a = 1'b1; addr_a = 3'd5; req_b = 1'b0; addr_b = 3'd0;
    tick(); tick();
    exp_rd_a = 4'h0; exp_rd_b = 4'h0;
    check_eq("rst gnt", 32'({o_gnt_a, o_gnt_b}), 32'd0);
    check_eq("rst rv", 32'({o_rv_a, o_rv_b}), 32'd0);
    check_eq("rst busy", 32'(o_busy), 32'd0);
    check_eq("rst rdata", 32'({o_rd_a, o_rd_b}), 32'd0);
    check_eq("rst rom_addr", 32'(o_rom_addr), 32'd0);
    req_a = 1'b0; rst_n = 1'b1;
    tick();
    check_eq("post rst gnt", 32'({o_gnt_a, o_gnt_b}), 32'd0);

    // Single read from A.
    req_a = 1'b1; addr_a = 3'd5;
    do_slot("single", 1'b0, 3'd5, 4'h7);
    req_a = 1'b0;
    tick();
    check_eq("single rv drop", 32'({o_rv_a, o_rv_b}), 32'd0);

    // Tie after reset: A first, then strict alternation.
    rst_n = 1'b0;
    tick();
    exp_rd_a = 4'h0; exp_rd_b = 4'h0;
    rst_n = 1'b1; req_a = 1'b1; req_b = 1'b1; addr_a = 3'd1; addr_b = 3'd7;
    do_slot("tie0", 1'b0, 3'd1, 4'h2);
    do_slot("tie1", 1'b1, 3'd7, 4'hb);
    do_slot("tie2", 1'b0, 3'd1, 4'h2);
    do_slot("tie3", 1'b1, 3'd7, 4'hb);
    req_a = 1'b0; req_b = 1'b0;

    // Lone requester B keeps winning with a new address each slot.
    req_b = 1'b1; addr_b = 3'd4;
    do_slot("lone0", 1'b1, 3'd4, 4'he);
    addr_b = 3'd7;
    do_slot("lone1", 1'b1, 3'd7, 4'hb);
    addr_b = 3'd1;
    do_slot("lone2", 1'b1, 3'd1, 4'h2);
    req_b = 1'b0;

    // B requests while A's access is in flight.
    req_a = 1'b1; addr_a = 3'd3;
    tick();
    check_eq("wreq gnt_a", 32'(o_gnt_a), 32'd1);
    req_a = 1'b0; req_b = 1'b1; addr_b = 3'd6;
    for (int j = 0; j < lat; j++) begin
      tick();
      check_eq("wreq no gnt_b", 32'(o_gnt_b), 32'd0);
    end
    tick();
    exp_rd_a = 4'h5;
    check_eq("wreq rv_a", 32'({o_rv_a, o_rv_b}), 32'd2);
    check_eq("wreq rdata_a", 32'(o_rd_a), 32'(exp_rd_a));
    check_eq("wreq gnt_b early", 32'(o_gnt_b), 32'd0);
    do_slot("wreq b", 1'b1, 3'd6, 4'h0);
    req_b = 1'b0;

    // Reset during WAIT aborts the access.
    req_a = 1'b1; addr_a = 3'd2;
    tick();
    check_eq("abort gnt_a", 32'(o_gnt_a), 32'd1);
    rst_n = 1'b0;
    tick();
    exp_rd_a = 4'h0; exp_rd_b = 4'h0;
    check_eq("abort busy", 32'(o_busy), 32'd0);
    check_eq("abort gnt", 32'({o_gnt_a, o_gnt_b}), 32'd0);
    rst_n = 1'b1; req_a = 1'b0;
    for (int j = 0; j < lat + 2; j++) begin
      tick();
      check_eq("abort no rv", 32'({o_rv_a, o_rv_b}), 32'd0);
    end
    req_a = 1'b1; req_b = 1'b1; addr_a = 3'd1; addr_b = 3'd7;
    do_slot("abort tie", 1'b0, 3'd1, 4'h2);
    req_a = 1'b0; req_b = 1'b0;
    tick();
    check_eq("end idle", 32'({o_gnt_a, o_gnt_b, o_rv_a, o_rv_b, o_busy}), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; req_a = 1'b0; req_b = 1'b0; addr_a = 3'd0; addr_b = 3'd0;
    lat_sel = 0; lat = 1;
    run_suite();
    lat_sel = 1; lat = 3;
    run_suite();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
